// File: rtl/bram_read_resp_adapter.sv
// Read-side front end for one BRAM port: valid/ready requests in, credit-protected response FIFO out.
// Optional same-cycle bypass of the FIFO when BRAM_RD_ADAPTER_BYPASS_EN is defined.
module bram_read_resp_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int PIPELINED  = 1,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  output logic                    BRAM_EN,
  output logic                    BRAM_WE,
  output logic [ADDR_WIDTH-1:0]   BRAM_ADDR,
  output logic                    BRAM_DEQ,
  output logic                    BRAM_CLR,
  input  logic [DATA_WIDTH-1:0]   BRAM_DO,
  output logic [$clog2(DEPTH):0]  OCCUPANCY
);

  localparam int LAT = 1 + PIPELINED;
  localparam int PW  = $clog2(DEPTH);
  localparam int OW  = PW + 1;
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);

  logic                  issue;
  logic                  pop;
  logic                  capture;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;

  logic [LAT-1:0]        vld_q, vld_d;
  logic [PW:0]           wr_q, wr_d;
  logic [PW:0]           rd_q, rd_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign REQ_READY = RST_N & (occ_q < OCC_MAX);
  assign issue     = REQ_VALID & REQ_READY;
  assign BRAM_EN   = issue;
  assign BRAM_ADDR = REQ_ADDR;
  assign BRAM_WE   = 1'b0;
  assign BRAM_CLR  = 1'b0;
  assign OCCUPANCY = occ_q;

  // vld_q[0]: read issued last cycle; vld_q[LAT-1]: BRAM_DO carries valid data now
  if (LAT == 1) begin : g_shift1
    assign vld_d = issue;
  end else begin : g_shiftn
    assign vld_d = {vld_q[LAT-2:0], issue};
  end

  assign capture  = vld_q[LAT-1];
  assign BRAM_DEQ = (PIPELINED != 0) ? vld_q[0] : 1'b0;

  assign empty = (wr_q == rd_q);
  assign head  = mem_q[rd_q[PW-1:0]];

`ifdef BRAM_RD_ADAPTER_BYPASS_EN
  // An empty FIFO forwards BRAM_DO directly; the word is stored only if not taken this cycle
  assign RSP_VALID = ~empty | capture;
  assign RSP_DATA  = empty ? BRAM_DO : head;
  assign fifo_wr   = capture & ~(empty & RSP_READY);
  assign fifo_rd   = ~empty & RSP_READY;
`else
  assign RSP_VALID = ~empty;
  assign RSP_DATA  = head;
  assign fifo_wr   = capture;
  assign fifo_rd   = ~empty & RSP_READY;
`endif

  assign pop = RSP_VALID & RSP_READY;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (fifo_wr) wr_d = wr_q + PTR_ONE;
    if (fifo_rd) rd_d = rd_q + PTR_ONE;
    occ_d = occ_q + OW'(issue) - OW'(pop);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) mem_q[wr_q[PW-1:0]] <= BRAM_DO;
  end

endmodule

// File: tb/tb_bram_read_resp_adapter.sv
// Scoreboard bench for bram_read_resp_adapter: a PIPELINED=1 instance with a queue-based
// monitor plus a PIPELINED=0 instance exercised with directed hold/release checks.
module tb_bram_read_resp_adapter;

`ifdef BRAM_RD_ADAPTER_BYPASS_EN
  localparam int EXP_LAT1 = 2;
  localparam logic EXP_P0_EARLY = 1'b1;
`else
  localparam int EXP_LAT1 = 3;
  localparam logic EXP_P0_EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // PIPELINED=1 instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [9:0]  req_addr, bram_addr;
  logic [31:0] rsp_data, bram_do, s1;
  logic        bram_en, bram_we, bram_deq, bram_clr;
  logic [2:0]  occ;

  // PIPELINED=0 instance
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0;
  logic [9:0]  req_addr0, bram_addr0;
  logic [31:0] rsp_data0, bram_do0;
  logic        bram_en0, bram_we0, bram_deq0, bram_clr0;
  logic [2:0]  occ0;

  bram_read_resp_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .PIPELINED(1), .DEPTH(4)) u_dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADDR(req_addr),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_ADDR(bram_addr), .BRAM_DEQ(bram_deq),
    .BRAM_CLR(bram_clr), .BRAM_DO(bram_do), .OCCUPANCY(occ)
  );

  bram_read_resp_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .PIPELINED(0), .DEPTH(4)) u_dut0 (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(req_valid0), .REQ_READY(req_ready0), .REQ_ADDR(req_addr0),
    .RSP_VALID(rsp_valid0), .RSP_READY(rsp_ready0), .RSP_DATA(rsp_data0),
    .BRAM_EN(bram_en0), .BRAM_WE(bram_we0), .BRAM_ADDR(bram_addr0), .BRAM_DEQ(bram_deq0),
    .BRAM_CLR(bram_clr0), .BRAM_DO(bram_do0), .OCCUPANCY(occ0)
  );

  function automatic logic [31:0] memv(input logic [9:0] a);
    return {16'hA5A5, 6'h00, a};
  endfunction

  // BRAM models: pipelined has an internal stage plus a DEQ-advanced output register
  always @(posedge clk) begin
    if (bram_en)  s1 <= memv(bram_addr);
    if (bram_deq) bram_do <= s1;
    if (bram_en0) bram_do0 <= memv(bram_addr0);
  end

  int total = 0;
  int bad = 0;
  int n_rsp = 0;
  logic we_seen = 1'b0;
  logic deq0_seen = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop/compare on each handshake, then record newly accepted requests
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got=%0h expected=none", rsp_data);
      end else begin
        exp_w = sb.pop_front();
        chk("rsp_data", {32'h0, rsp_data}, {32'h0, exp_w});
      end
    end
    if (rst_n && req_valid && req_ready) sb.push_back(memv(req_addr));
    if (bram_we || bram_clr || bram_we0 || bram_clr0) we_seen = 1'b1;
    if (bram_deq0) deq0_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  int lat, n, g, base, drops, spur;
  logic [7:0] pat;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b1; req_addr = 10'd5; rsp_ready = 1'b1;
    req_valid0 = 1'b1; req_addr0 = 10'd7; rsp_ready0 = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_bram_en",   {63'h0, bram_en}, 64'h0);
    chk("rst_bram_deq",  {63'h0, bram_deq}, 64'h0);
    chk("rst_occ",       {61'h0, occ}, 64'h0);
    chk("rst_bram_en0",  {63'h0, bram_en0}, 64'h0);
    req_valid = 1'b0; req_valid0 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {63'h0, req_ready}, 64'h1);

    // single read latency
    req_valid = 1'b1; req_addr = 10'd5; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    chk("t1_latency", 64'(lat), 64'(EXP_LAT1));
    tick();
    chk("t1_occ", {61'h0, occ}, 64'h0);

    // back-to-back streaming
    base = n_rsp; drops = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 10'(i);
      if (!req_ready) drops++;
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();
    chk("t2_ready_drops", 64'(drops), 64'h0);
    chk("t2_rsp_count", 64'(n_rsp - base), 64'd16);
    chk("t2_occ", {61'h0, occ}, 64'h0);

    // back-pressure: only DEPTH requests accepted
    rsp_ready = 1'b0; n = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_addr = 10'(100 + n);
      if (req_ready) n++;
      tick();
    end
    chk("t3_accepted", 64'(n), 64'd4);
    chk("t3_ready_full", {63'h0, req_ready}, 64'h0);
    chk("t3_occ_full", {61'h0, occ}, 64'd4);
    rsp_ready = 1'b1; g = 0;
    while (n < 6 && g < 20) begin
      req_addr = 10'(100 + n);
      if (req_ready) n++;
      tick(); g++;
    end
    req_valid = 1'b0;
    repeat (6) tick();
    chk("t3_accepted_all", 64'(n), 64'd6);
    chk("t3_sb_empty", 64'(sb.size()), 64'h0);
    chk("t3_occ", {61'h0, occ}, 64'h0);

    // pointer wrap under mixed issue/pop
    base = n_rsp; rsp_ready = 1'b0; n = 0; g = 0; pat = 8'b1011_0111;
    while (n < 16 && g < 100) begin
      req_valid = 1'b1; req_addr = 10'(300 + 7 * n);
      if (n >= 4) rsp_ready = pat[g % 8];
      if (req_ready) n++;
      tick(); g++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (10) tick();
    chk("t4_accepted", 64'(n), 64'd16);
    chk("t4_rsp_count", 64'(n_rsp - base), 64'd16);
    chk("t4_occ", {61'h0, occ}, 64'h0);

    // reset with reads in flight and in the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 10'(200 + i);
      tick();
    end
    req_valid = 1'b0;
    chk("t5_occ_before", {61'h0, occ}, 64'd4);
    chk("t5_valid_before", {63'h0, rsp_valid}, 64'h1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_occ_in_rst", {61'h0, occ}, 64'h0);
    chk("t5_valid_in_rst", {63'h0, rsp_valid}, 64'h0);
    repeat (3) tick();
    rst_n = 1'b1; rsp_ready = 1'b1; spur = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) spur++;
    end
    chk("t5_spurious_valid", 64'(spur), 64'h0);
    chk("t5_occ_after", {61'h0, occ}, 64'h0);
    base = n_rsp;
    req_valid = 1'b1; req_addr = 10'd9;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("t5_rsp_count", 64'(n_rsp - base), 64'd1);

    // PIPELINED=0 instance: hold and release
    req_valid0 = 1'b1; req_addr0 = 10'd7; rsp_ready0 = 1'b0;
    tick();
    req_addr0 = 10'd8;
    chk("t6_early_valid", {63'h0, rsp_valid0}, {63'h0, EXP_P0_EARLY});
    tick();
    req_valid0 = 1'b0;
    chk("t6_valid", {63'h0, rsp_valid0}, 64'h1);
    chk("t6_data7", {32'h0, rsp_data0}, {32'h0, memv(10'd7)});
    tick();
    chk("t6_data7_held", {32'h0, rsp_data0}, {32'h0, memv(10'd7)});
    chk("t6_occ2", {61'h0, occ0}, 64'd2);
    rsp_ready0 = 1'b1;
    tick();
    chk("t6_data8", {32'h0, rsp_data0}, {32'h0, memv(10'd8)});
    rsp_ready0 = 1'b0;
    tick();
    chk("t6_data8_held", {32'h0, rsp_data0}, {32'h0, memv(10'd8)});
    chk("t6_valid8_held", {63'h0, rsp_valid0}, 64'h1);
    rsp_ready0 = 1'b1;
    tick();
    chk("t6_valid_done", {63'h0, rsp_valid0}, 64'h0);
    chk("t6_occ0", {61'h0, occ0}, 64'h0);
    chk("t6_deq_never", {63'h0, deq0_seen}, 64'h0);

    chk("we_clr_never", {63'h0, we_seen}, 64'h0);
    chk("final_sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
